// File: rtl/frame_loader.sv
// frame_loader: writer side of the LED-matrix frame buffer.
// Waits for a start-of-frame byte and packs the following bytes six at a time
// into 48-bit RAM words ({B2,G2,R2,B1,G1,R1}, byte0 in [7:0]). It writes WORDS
// words, then pulses frame_done. If the stream stalls for TIMEOUT cycles
// mid-frame, it pulses frame_err instead.
// Build option: define DOUBLE_BUFFER_EN to write the hidden bank and swap
// disp_bank at each completed frame; otherwise bank 0 is used throughout.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_data/in_valid      byte stream input; in_ready (combinational) accepts
//   ram_we/waddr/wdata    one-cycle RAM write per word; waddr[9] is the bank
//   disp_bank             bank currently shown by the display
//   busy                  high while a frame is in progress
//   frame_done/frame_err  one-cycle completion / timeout-abort pulses
module frame_loader #(
  parameter int unsigned WORDS    = 512,
  parameter logic [7:0]  SOF_BYTE = 8'hA5,
  parameter int unsigned TIMEOUT  = 50000,
  parameter int unsigned TMO_W    = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        ram_we,
  output logic [9:0]  ram_waddr,
  output logic [47:0] ram_wdata,
  output logic        disp_bank,
  output logic        busy,
  output logic        frame_done,
  output logic        frame_err
);

  localparam int unsigned ADDR_W = 9;
  localparam int unsigned IDX_W  = 3;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORDS - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(5);

`ifdef DOUBLE_BUFFER_EN
  localparam logic DBUF = 1'b1;
`else
  localparam logic DBUF = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_RECV, S_WRITE, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic [47:0]         word_q, word_d;
  logic                ram_we_d, disp_bank_d, busy_d, frame_done_d, frame_err_d;
  logic [9:0]          ram_waddr_d;
  logic [47:0]         ram_wdata_d;
  logic                accept;
  logic                bank_bit;

  // Accept bytes only while idle-hunting for SOF or receiving frame data.
  assign in_ready = (state_q == S_IDLE) || (state_q == S_RECV);
  assign accept   = in_valid && in_ready;
  // Writes target the hidden bank when double buffering, else bank 0.
  assign bank_bit = DBUF & ~disp_bank;

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    idx_d        = idx_q;
    tmo_d        = tmo_q;
    word_d       = word_q;
    ram_we_d     = 1'b0;
    ram_waddr_d  = ram_waddr;
    ram_wdata_d  = ram_wdata;
    disp_bank_d  = disp_bank;
    frame_done_d = 1'b0;
    frame_err_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept && (in_data == SOF_BYTE)) begin
          state_d = S_RECV;
          addr_d  = '0;
          idx_d   = '0;
          tmo_d   = '0;
        end
      end
      S_RECV: begin
        if (accept) begin
          word_d[{idx_q, 3'b000} +: 8] = in_data;
          tmo_d = '0;
          if (idx_q == LAST_IDX) begin
            // Sixth byte: the complete word is presented on the next cycle.
            state_d     = S_WRITE;
            idx_d       = '0;
            ram_we_d    = 1'b1;
            ram_waddr_d = {bank_bit, addr_q};
            ram_wdata_d = word_d;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else if (tmo_q == TMO_LAST) begin
          // Stream stalled: abandon the frame, keep what is already written.
          state_d     = S_IDLE;
          addr_d      = '0;
          idx_d       = '0;
          frame_err_d = 1'b1;
        end else if (tmo_q != '1) begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_WRITE: begin
        if (addr_q == LAST_ADDR) begin
          state_d      = S_DONE;
          frame_done_d = 1'b1;
          disp_bank_d  = disp_bank ^ DBUF;
        end else begin
          state_d = S_RECV;
          addr_d  = addr_q + ADDR_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        addr_d  = '0;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      idx_q      <= '0;
      tmo_q      <= '0;
      word_q     <= '0;
      ram_we     <= 1'b0;
      ram_waddr  <= '0;
      ram_wdata  <= '0;
      disp_bank  <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      idx_q      <= idx_d;
      tmo_q      <= tmo_d;
      word_q     <= word_d;
      ram_we     <= ram_we_d;
      ram_waddr  <= ram_waddr_d;
      ram_wdata  <= ram_wdata_d;
      disp_bank  <= disp_bank_d;
      busy       <= busy_d;
      frame_done <= frame_done_d;
      frame_err  <= frame_err_d;
    end
  end

endmodule

// File: tb/tb_frame_loader.sv
// Testbench for frame_loader. A transaction-level model turns accepted bytes
// and idle gaps into expected write/done/error events in a queue; a monitor
// pops the queue and compares whenever the DUT raises a strobe.
module tb_frame_loader;

  localparam int unsigned WORDS   = 512;
  localparam int unsigned TIMEOUT = 16;
  localparam logic [7:0]  SOF     = 8'hA5;
`ifdef DOUBLE_BUFFER_EN
  localparam bit DB = 1'b1;
`else
  localparam bit DB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        ram_we;
  logic [9:0]  ram_waddr;
  logic [47:0] ram_wdata;
  logic        disp_bank;
  logic        busy;
  logic        frame_done;
  logic        frame_err;

  frame_loader #(
    .WORDS(WORDS), .SOF_BYTE(SOF), .TIMEOUT(TIMEOUT), .TMO_W(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .ram_we(ram_we), .ram_waddr(ram_waddr),
    .ram_wdata(ram_wdata), .disp_bank(disp_bank), .busy(busy),
    .frame_done(frame_done), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // kind: 0 = RAM write, 1 = frame_done, 2 = frame_err
  typedef struct {
    int          kind;
    logic [9:0]  addr;
    logic [47:0] data;
    logic        bank;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  done_cnt = 0;
  int  err_cnt = 0;
  int  rdy_low = 0;

  // Reference model state
  bit          m_in_frame;
  int          m_cnt;
  int          m_widx;
  int          m_idle;
  bit          m_prev_wordend;
  bit          m_bank;
  logic [47:0] m_word;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_in_frame = 1'b0; m_cnt = 0; m_widx = 0; m_idle = 0;
    m_prev_wordend = 1'b0; m_bank = 1'b0; m_word = '0;
  endfunction

  // g silent cycles; the write cycle right after a word does not count as silence
  function automatic void model_gap(input int g);
    if (g > 0) begin
      m_idle += m_prev_wordend ? g - 1 : g;
      m_prev_wordend = 1'b0;
    end
    if (m_in_frame && (m_idle >= int'(TIMEOUT))) begin
      exp_q.push_back('{2, 10'd0, 48'd0, m_bank});
      m_in_frame = 1'b0;
    end
  endfunction

  function automatic void model_accept(input logic [7:0] b, output bit wend);
    wend = 1'b0;
    m_idle = 0;
    m_prev_wordend = 1'b0;
    if (!m_in_frame) begin
      if (b == SOF) begin
        m_in_frame = 1'b1; m_cnt = 0; m_widx = 0;
      end
    end else begin
      m_word[8*m_cnt +: 8] = b;
      m_cnt++;
      if (m_cnt == 6) begin
        wend = 1'b1;
        m_prev_wordend = 1'b1;
        m_cnt = 0;
        exp_q.push_back('{0, {DB & ~m_bank, 9'(m_widx)}, m_word, m_bank});
        if (m_widx == int'(WORDS) - 1) begin
          if (DB) m_bank = ~m_bank;
          exp_q.push_back('{1, 10'd0, 48'd0, m_bank});
          m_in_frame = 1'b0;
        end else begin
          m_widx++;
        end
      end
    end
  endfunction

  // Present one byte after `gap` idle cycles; leaves in_valid high afterwards.
  task automatic send_byte(input logic [7:0] b, input int gap);
    bit hs;
    bit wend;
    int n;
    model_gap(gap);
    if (gap > 0) begin
      in_valid = 1'b0;
      repeat (gap) @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_data  = b;
    hs = 1'b0;
    n  = 0;
    while (!hs && n < 8) begin
      @(negedge clk);
      hs = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!hs) begin
      check("handshake_timeout", 64'(hs), 64'd1);
    end else begin
      model_accept(b, wend);
      if (wend) check("we_latency", 64'(ram_we), 64'd1);
    end
  endtask

  task automatic idle(input int g);
    model_gap(g);
    in_valid = 1'b0;
    repeat (g) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"},   64'(in_ready),   64'd1);
    check({tag, "_busy"},       64'(busy),       64'd0);
    check({tag, "_ram_we"},     64'(ram_we),     64'd0);
    check({tag, "_ram_waddr"},  64'(ram_waddr),  64'd0);
    check({tag, "_ram_wdata"},  64'(ram_wdata),  64'd0);
    check({tag, "_disp_bank"},  64'(disp_bank),  64'd0);
    check({tag, "_frame_done"}, 64'(frame_done), 64'd0);
    check({tag, "_frame_err"},  64'(frame_err),  64'd0);
  endtask

  // Monitor: pop and compare on every strobe
  always @(negedge clk) begin
    ev_t e;
    int  kind;
    if (rst_n) begin
      if (!in_ready) rdy_low++;
      if (ram_we || frame_done || frame_err) begin
        kind = ram_we ? 0 : (frame_done ? 1 : 2);
        check("one_strobe", 64'(ram_we) + 64'(frame_done) + 64'(frame_err), 64'd1);
        if (kind == 1) done_cnt++;
        if (kind == 2) err_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event kind=%0d required=none", kind);
        end else begin
          e = exp_q.pop_front();
          check("event_kind", 64'(kind), 64'(e.kind));
          if (kind == 0) begin
            check("waddr", 64'(ram_waddr), 64'(e.addr));
            check("wdata", 64'(ram_wdata), 64'(e.data));
          end else begin
            check("disp_bank", 64'(disp_bank), 64'(e.bank));
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, e0, r0, first;
    logic [7:0] b;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("rst");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Junk, then SOF and a full counting frame with in_valid held high
    d0 = done_cnt; e0 = err_cnt; r0 = rdy_low;
    send_byte(8'h00, 0);
    send_byte(8'h11, 0);
    send_byte(SOF, 0);
    check("t1_busy", 64'(busy), 64'd1);
    for (int i = 0; i < 6 * int'(WORDS); i++) begin
      send_byte(8'(i), 0);
      if (i == 5) begin
        check("t1_word0", 64'(ram_wdata), 64'h050403020100);
        check("t1_addr0", 64'(ram_waddr[8:0]), 64'd0);
      end
    end
    check("t1_last_addr", 64'(ram_waddr[8:0]), 64'd511);
    idle(4);
    check("t1_done_cnt", 64'(done_cnt - d0), 64'd1);
    check("t1_err_cnt", 64'(err_cnt - e0), 64'd0);
    check("t1_ready_low", 64'(rdy_low - r0), 64'(WORDS + 1));
    check("t1_busy_end", 64'(busy), 64'd0);
    check("t1_bank", 64'(disp_bank), 64'(m_bank));

    // SOF, 7 bytes, silence: one word, then abort TIMEOUT cycles later
    e0 = err_cnt;
    send_byte(SOF, 3);
    for (int i = 0; i < 7; i++) send_byte(8'(8'h30 + i), 0);
    check("t3_busy", 64'(busy), 64'd1);
    in_valid = 1'b0;
    model_gap(40);
    first = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (frame_err && first == 0) first = k;
    end
    check("t3_err_latency", 64'(first), 64'(TIMEOUT));
    check("t3_err_cnt", 64'(err_cnt - e0), 64'd1);
    check("t3_idle", 64'(busy), 64'd0);
    check("t3_bank", 64'(disp_bank), 64'(m_bank));

    // SOF as first data byte is plain data; restart at addr 0
    send_byte(SOF, 0);
    send_byte(SOF, 0);
    for (int i = 1; i < 6; i++) send_byte(8'(i), 0);
    check("t4_lane0", 64'(ram_wdata[7:0]), 64'hA5);
    check("t4_addr", 64'(ram_waddr[8:0]), 64'd0);
    // gap just after a word: the write cycle does not count toward timeout
    send_byte(8'h77, int'(TIMEOUT));
    // gap one short of the timeout mid-word survives
    send_byte(8'h78, int'(TIMEOUT) - 1);
    check("t4_busy", 64'(busy), 64'd1);
    e0 = err_cnt;
    idle(int'(TIMEOUT));
    idle(2);
    check("t4_err_cnt", 64'(err_cnt - e0), 64'd1);

    // Random junk and a random frame with random gaps
    d0 = done_cnt;
    for (int i = 0; i < 5; i++) begin
      b = 8'($urandom_range(0, 255));
      if (b == SOF) b = 8'h00;
      send_byte(b, int'($urandom_range(0, 3)));
    end
    send_byte(SOF, 1);
    for (int i = 0; i < 6 * int'(WORDS); i++)
      send_byte(8'($urandom_range(0, 255)), int'($urandom_range(0, 3)));
    idle(4);
    check("t6_done_cnt", 64'(done_cnt - d0), 64'd1);
    check("t6_bank", 64'(disp_bank), 64'(m_bank));

    // Reset in the middle of a frame
    send_byte(SOF, 2);
    for (int i = 0; i < 100; i++)
      send_byte(8'($urandom_range(0, 255)), int'($urandom_range(0, 2)));
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("midrst");
    check("midrst_pending", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    d0 = done_cnt;
    send_byte(SOF, 0);
    for (int i = 0; i < 6 * int'(WORDS); i++) begin
      send_byte(8'($urandom_range(0, 255)), 0);
      if (i == 5) check("t5_addr0", 64'(ram_waddr[8:0]), 64'd0);
    end
    idle(4);
    check("t5_done_cnt", 64'(done_cnt - d0), 64'd1);
    check("t5_bank", 64'(disp_bank), 64'(m_bank));

    check("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
